// File: rtl/firebird7_in_gate1_tessent_mux_ctrl_pkg.sv
// Shared types and TDR field layout for the gate1 Tessent mux takeover controller.
package firebird7_in_gate1_tessent_mux_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DRAIN      = 3'd1,
        SETTLE_ON  = 3'd2,
        ACTIVE     = 3'd3,
        SETTLE_OFF = 3'd4
    } state_t;

    localparam int REQ_BIT  = 0;
    localparam int CLR_BIT  = 1;
    localparam int DATA_LSB = 2;

endpackage

// File: rtl/firebird7_in_gate1_tessent_mux_ctrl_tdr.sv
// IJTAG capture/shift/update register holding the override request and data.
module firebird7_in_gate1_tessent_mux_ctrl_tdr
    import firebird7_in_gate1_tessent_mux_ctrl_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             ce,
    input  logic             se,
    input  logic             ue,
    input  logic             si,
    input  logic [WIDTH+1:0] capture_value,
    output logic             so,
    output logic             req_u,
    output logic [WIDTH-1:0] data_u,
    output logic             err_clear
);

    logic [WIDTH+1:0] shift_reg;
    logic             update_en;
    logic             capture_en;
    logic             shift_en;

    // Update wins over capture if the network ever asserts both.
    assign update_en  = sel & ue;
    assign capture_en = sel & ce & ~update_en;
    assign shift_en   = sel & se;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            req_u     <= 1'b0;
            data_u    <= '0;
        end else begin
            if (update_en) begin
                req_u  <= shift_reg[REQ_BIT];
                data_u <= shift_reg[WIDTH+1:DATA_LSB];
            end
            if (capture_en) begin
                shift_reg <= capture_value;
            end else if (shift_en) begin
                shift_reg <= {si, shift_reg[WIDTH+1:1]};
            end
        end
    end

    // Clear acts on the update edge itself so a coincident timeout can override it.
    assign err_clear = update_en & shift_reg[CLR_BIT];
    assign so        = shift_reg[0];

endmodule

// File: rtl/firebird7_in_gate1_tessent_mux_takeover_ctrl.sv
// Sequences the Tessent data-mux select: quiesce request, idle handshake, settle, takeover and release.
module firebird7_in_gate1_tessent_mux_takeover_ctrl
    import firebird7_in_gate1_tessent_mux_ctrl_pkg::*;
#(
    parameter int WIDTH          = 3,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic             func_idle,
    output logic             func_hold,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             busy,
    output logic             timeout_err,
    output logic [2:0]       fsm_state
);

    localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    logic             req_u;
    logic [WIDTH-1:0] data_u;
    logic             err_clear;

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [15:0] tcnt, tcnt_nx;
    logic        armed, armed_nx;
    logic        err_set;
    logic        err_nx;

    firebird7_in_gate1_tessent_mux_ctrl_tdr #(
        .WIDTH(WIDTH)
    ) u_tdr (
        .clk           (ijtag_tck),
        .rst_n         (ijtag_reset),
        .sel           (ijtag_sel),
        .ce            (ijtag_ce),
        .se            (ijtag_se),
        .ue            (ijtag_ue),
        .si            (ijtag_si),
        .capture_value ({data_u, timeout_err, ijtag_select}),
        .so            (ijtag_so),
        .req_u         (req_u),
        .data_u        (data_u),
        .err_clear     (err_clear)
    );

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            tcnt         <= '0;
            armed        <= 1'b1;
            func_hold    <= 1'b0;
            ijtag_select <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            tcnt         <= tcnt_nx;
            armed        <= armed_nx;
            func_hold    <= (state_nx != IDLE);
            ijtag_select <= (state_nx == ACTIVE);
            busy         <= (state_nx != IDLE);
            timeout_err  <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tcnt_nx  = tcnt;
        armed_nx = armed | ~req_u;
        err_set  = 1'b0;
        case (state)
            IDLE: begin
                if (req_u && armed) begin
                    state_nx = DRAIN;
                    tcnt_nx  = '0;
                end
            end
            DRAIN: begin
                if (!req_u) begin
                    state_nx = IDLE;
                end else if (func_idle) begin
                    state_nx = SETTLE_ON;
                    cnt_nx   = SETTLE_LOAD;
                end else begin
                    tcnt_nx = tcnt + 16'd1;
                    if (tcnt_nx == TIMEOUT_LIM) begin
                        // Disarm so a retry needs an explicit 0-then-1 request write.
                        err_set  = 1'b1;
                        armed_nx = 1'b0;
                        state_nx = IDLE;
                    end
                end
            end
            SETTLE_ON: begin
                if (!req_u) begin
                    state_nx = SETTLE_OFF;
                    cnt_nx   = SETTLE_LOAD;
                end else if (cnt == 8'd0) begin
                    state_nx = ACTIVE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            ACTIVE: begin
                if (!req_u) begin
                    state_nx = SETTLE_OFF;
                    cnt_nx   = SETTLE_LOAD;
                end
            end
            SETTLE_OFF: begin
                if (cnt == 8'd0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        err_nx = err_set ? 1'b1 : (err_clear ? 1'b0 : timeout_err);
    end

    assign ijtag_data_out = data_u;
    assign fsm_state      = state;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_mux_takeover_ctrl.sv
// Directed bench for the gate1 Tessent mux takeover controller at default parameters.
module tb_firebird7_in_gate1_tessent_mux_takeover_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel, ce, se, ue, si;
  logic       so;
  logic       func_idle;
  logic       hold, select, busy, terr;
  logic [2:0] data_out;
  logic [2:0] fsm_state;

  int tests = 0;
  int fails = 0;
  logic [4:0] cap;

  firebird7_in_gate1_tessent_mux_takeover_ctrl dut (
    .ijtag_tck      (clk),
    .ijtag_reset    (rst_n),
    .ijtag_sel      (sel),
    .ijtag_ce       (ce),
    .ijtag_se       (se),
    .ijtag_ue       (ue),
    .ijtag_si       (si),
    .ijtag_so       (so),
    .func_idle      (func_idle),
    .func_hold      (hold),
    .ijtag_select   (select),
    .ijtag_data_out (data_out),
    .busy           (busy),
    .timeout_err    (terr),
    .fsm_state      (fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_in(input logic [4:0] v);
    se = 1'b1;
    for (int i = 0; i < 5; i++) begin
      si = v[i];
      @(negedge clk);
    end
    se = 1'b0;
    si = 1'b0;
  endtask

  task automatic shift_out(output logic [4:0] v);
    for (int i = 0; i < 5; i++) begin
      v[i] = so;
      se = 1'b1;
      si = 1'b0;
      @(negedge clk);
    end
    se = 1'b0;
  endtask

  task automatic do_update();
    ue = 1'b1;
    @(negedge clk);
    ue = 1'b0;
  endtask

  task automatic do_capture();
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    func_idle = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    sel = 1'b1;
    wait_cycles(1);

    // reset state
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_select", 32'(select), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_terr", 32'(terr), 32'd0);
    check("rst_so", 32'(so), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    do_capture();
    shift_out(cap);
    check("rst_capture_stream", 32'(cap), 32'h00);

    // takeover: req=1, data=101, func_idle high
    func_idle = 1'b1;
    shift_in(5'b10101);
    do_update();                    // edge N
    check("on_hold_N", 32'(hold), 32'd0);
    check("on_data_N", 32'(data_out), 32'h5);
    wait_cycles(1);                 // N+1
    check("on_hold_N1", 32'(hold), 32'd1);
    check("on_busy_N1", 32'(busy), 32'd1);
    check("on_sel_N1", 32'(select), 32'd0);
    wait_cycles(4);                 // N+5
    check("on_sel_N5", 32'(select), 32'd0);
    wait_cycles(1);                 // N+6
    check("on_sel_N6", 32'(select), 32'd1);
    check("on_state_N6", 32'(fsm_state), 32'd3);
    do_capture();
    shift_out(cap);
    check("active_capture", 32'(cap), 32'h15);

    // release
    shift_in(5'b10100);
    do_update();                    // edge R
    check("off_sel_R", 32'(select), 32'd1);
    wait_cycles(1);                 // R+1
    check("off_sel_R1", 32'(select), 32'd0);
    check("off_hold_R1", 32'(hold), 32'd1);
    wait_cycles(3);                 // R+4
    check("off_hold_R4", 32'(hold), 32'd1);
    wait_cycles(1);                 // R+5
    check("off_hold_R5", 32'(hold), 32'd0);
    check("off_busy_R5", 32'(busy), 32'd0);

    // drain timeout
    func_idle = 1'b0;
    shift_in(5'b00001);
    do_update();                    // edge N
    wait_cycles(1);
    check("to_hold_N1", 32'(hold), 32'd1);
    wait_cycles(254);               // N+255
    check("to_terr_N255", 32'(terr), 32'd0);
    check("to_hold_N255", 32'(hold), 32'd1);
    wait_cycles(1);                 // N+256
    check("to_terr_N256", 32'(terr), 32'd1);
    check("to_hold_N256", 32'(hold), 32'd0);
    check("to_state_N256", 32'(fsm_state), 32'd0);

    // rewrite req=1 while disarmed
    shift_in(5'b00001);
    do_update();
    wait_cycles(5);
    check("disarmed_hold", 32'(hold), 32'd0);

    // re-arm with 0 then 1
    shift_in(5'b00000);
    do_update();
    func_idle = 1'b1;
    shift_in(5'b00001);
    do_update();
    wait_cycles(5);
    check("rearm_sel_N5", 32'(select), 32'd0);
    wait_cycles(1);
    check("rearm_sel_N6", 32'(select), 32'd1);
    shift_in(5'b00000);
    do_update();
    wait_cycles(5);
    check("rearm_off_hold", 32'(hold), 32'd0);

    // clear, then second timeout coincident with err_clear
    shift_in(5'b00010);
    do_update();
    check("clr_terr", 32'(terr), 32'd0);
    func_idle = 1'b0;
    shift_in(5'b00001);
    do_update();                    // edge N
    wait_cycles(250);
    shift_in(5'b00011);             // ends after N+255
    check("to2_terr_N255", 32'(terr), 32'd0);
    do_update();                    // edge N+256 with err_clear
    check("to2_terr_wins", 32'(terr), 32'd1);
    check("to2_hold", 32'(hold), 32'd0);
    shift_in(5'b00010);
    do_update();
    check("to2_clear_after", 32'(terr), 32'd0);

    // async reset while ACTIVE
    func_idle = 1'b1;
    shift_in(5'b11101);
    do_update();
    wait_cycles(6);
    check("rst_act_sel", 32'(select), 32'd1);
    check("rst_act_data", 32'(data_out), 32'h7);
    #2 rst_n = 1'b0;
    #1;
    check("async_sel", 32'(select), 32'd0);
    check("async_hold", 32'(hold), 32'd0);
    check("async_data", 32'(data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(4);
    check("post_rst_hold", 32'(hold), 32'd0);
    check("post_rst_state", 32'(fsm_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
